// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame on device clock, ack check.
// Optional `PS2_TX_RETRY_EN: one automatic resend of the same byte after a NACK; busy stays high across it.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_start,
  input  logic [7:0] send_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic          INH_ONE  = (INHIBIT_CYCLES == 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic          clk_drv_q, clk_drv_d, data_drv_q, data_drv_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
`ifdef PS2_TX_RETRY_EN
  logic          retry_q, retry_d;
  logic [7:0]    byte_q, byte_d;
`endif

  logic       fall;
  logic       to_hit;
  logic [3:0] edge_inc;
  logic       fail_now;
  logic       nack;

  assign fall     = clk_prev_q & ~clk_s2_q;
  assign to_hit   = (cnt_q == TO_LAST);
  assign edge_inc = (edge_cnt_q == 4'hF) ? edge_cnt_q : edge_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    shift_d    = shift_q;
    clk_s1_d   = ps2_clk_in;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    data_s1_d  = ps2_data_in;
    data_s2_d  = data_s1_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    fail_now   = 1'b0;
    nack       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
    byte_d     = byte_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (send_start) begin
          shift_d    = {~^send_data, send_data};
          state_d    = S_INHIBIT;
          busy_d     = 1'b1;
          cnt_d      = '0;
          edge_cnt_d = 4'd0;
          clk_drv_d  = 1'b1;
          data_drv_d = INH_ONE;
`ifdef PS2_TX_RETRY_EN
          byte_d     = send_data;
          retry_d    = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + CNT_ONE;
        // Start bit goes out during the final inhibit cycle, before the clock is released.
        if (cnt_q == INH_PRE) data_drv_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          state_d    = S_REQ;
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b1;
          cnt_d      = '0;
        end
      end
      S_REQ, S_DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (to_hit) begin
          fail_now = 1'b1;
        end else if (fall) begin
          edge_cnt_d = edge_inc;
          if (edge_cnt_q < 4'd9) begin
            data_drv_d = ~shift_q[0];
            shift_d    = {1'b0, shift_q[8:1]};
            state_d    = S_DATA;
          end else begin
            data_drv_d = 1'b0;
            state_d    = S_ACK;
          end
        end
      end
      S_ACK: begin
        cnt_d = cnt_q + CNT_ONE;
        if (to_hit) begin
          fail_now = 1'b1;
        end else if (fall) begin
          edge_cnt_d = edge_inc;
          if (!data_s2_q) state_d = S_WAIT_IDLE;
          else            nack    = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (to_hit) begin
          fail_now = 1'b1;
        end else if (clk_s2_q && data_s2_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (nack) begin
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d    = 1'b1;
        shift_d    = {~^byte_q, byte_q};
        state_d    = S_INHIBIT;
        cnt_d      = '0;
        edge_cnt_d = 4'd0;
        clk_drv_d  = 1'b1;
        data_drv_d = INH_ONE;
      end else begin
        fail_now = 1'b1;
      end
`else
      fail_now = 1'b1;
`endif
    end

    if (fail_now) begin
      state_d    = S_IDLE;
      clk_drv_d  = 1'b0;
      data_drv_d = 1'b0;
      busy_d     = 1'b0;
      error_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= 4'd0;
      shift_q    <= 9'd0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= 1'b0;
      byte_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shift_q    <= shift_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
      byte_q     <= byte_d;
`endif
    end
  end

  // Gating with reset lets a mid-frame reset free the bus in the cycle it is raised.
  assign ps2_clk_drive_low  = clk_drv_q  & ~reset;
  assign ps2_data_drive_low = data_drv_q & ~reset;
  assign busy               = busy_q     & ~reset;
  assign done               = done_q     & ~reset;
  assign error              = error_q    & ~reset;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, expected frames/results queued at stimulus time, one monitor compares.
module tb_ps2_host_tx;
  localparam int INH = 4;
  localparam int TO  = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send_start = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low, busy, done, error;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .send_start(send_start), .send_data(send_data),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          inh_run = 0;
  chk_t        direct_q[$];
  logic [10:0] exp_frame_q[$];
  logic [10:0] got_frame_q[$];
  logic [1:0]  exp_res_q[$];   // {done,error}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.exp  = exp;
    direct_q.push_back(c);
  endtask

  // Single monitor: drains direct checks, result pulses, captured frames and inhibit lengths.
  always @(negedge clock) begin
    chk_t        c;
    logic [1:0]  r;
    logic [10:0] g, e;
    while (direct_q.size() > 0) begin
      c = direct_q.pop_front();
      check(c.name, c.got, c.exp);
    end
    if (done || error) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, error}, 32'd0);
      end else begin
        r = exp_res_q.pop_front();
        check("result", {30'd0, done, error}, {30'd0, r});
      end
    end
    if (got_frame_q.size() > 0) begin
      g = got_frame_q.pop_front();
      if (exp_frame_q.size() == 0) begin
        check("unexpected_frame", {21'd0, g}, 32'd0);
      end else begin
        e = exp_frame_q.pop_front();
        check("frame", {21'd0, g}, {21'd0, e});
      end
    end
    if (ps2_clk_drive_low) begin
      inh_run++;
    end else if (inh_run != 0) begin
      check("inhibit_len", inh_run, INH);
      inh_run = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clock);
    #1 send_start = 1'b1;
    send_data = b;
    @(posedge clock);
    #1 send_start = 1'b0;
    send_data = 8'hFF;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    @(negedge clock);
    while (!(ps2_clk_drive_low == 1'b0 && ps2_data_drive_low == 1'b1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) expect_eq("req_wait_expired", n, 0);
  endtask

  // Device: clocks 11 edges at a 40-cycle period, samples on rising edges, acks (or not) at edge 11.
  task automatic device_frame(input bit ack, input int abort_edge);
    logic [10:0] f;
    int n;
    f = '0;
    wait_req(n);
    if (n >= 200) return;
    f[0] = ps2_data_in;
    repeat (10) @(negedge clock);
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      if (i == abort_edge) begin
        repeat (10) @(negedge clock);
        return;
      end
      repeat (20) @(negedge clock);
      dev_clk = 1'b1;
      if (i <= 10) f[i] = ps2_data_in;
      if (i == 10) dev_data = ack ? 1'b0 : 1'b1;
      if (i == 11) dev_data = 1'b1;
      repeat (20) @(negedge clock);
    end
    got_frame_q.push_back(f);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) expect_eq({tag, "_busy_stuck"}, 32'(busy), 32'd0);
    expect_eq({tag, "_clk_rel"},  32'(ps2_clk_drive_low),  32'd0);
    expect_eq({tag, "_data_rel"}, 32'(ps2_data_drive_low), 32'd0);
  endtask

  initial begin
    int n;
    repeat (5) @(posedge clock);
    @(negedge clock);
    expect_eq("rst_clk_drv",  32'(ps2_clk_drive_low),  32'd0);
    expect_eq("rst_data_drv", 32'(ps2_data_drive_low), 32'd0);
    expect_eq("rst_busy",     32'(busy),  32'd0);
    expect_eq("rst_done",     32'(done),  32'd0);
    expect_eq("rst_error",    32'(error), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // 0xED: parity 1
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    exp_res_q.push_back(2'b10);
    send(8'hED);
    @(negedge clock);
    expect_eq("busy_after_start", 32'(busy), 32'd1);
    device_frame(1'b1, 0);
    wait_idle("happy");

    // 0xF4: parity 0
    exp_frame_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
    exp_res_q.push_back(2'b10);
    send(8'hF4);
    device_frame(1'b1, 0);
    wait_idle("f4");

    // 0x00: parity 1
    exp_frame_q.push_back({1'b1, 1'b1, 8'h00, 1'b0});
    exp_res_q.push_back(2'b10);
    send(8'h00);
    device_frame(1'b1, 0);
    wait_idle("zero");

    // start while busy is ignored
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    exp_res_q.push_back(2'b10);
    send(8'hED);
    repeat (2) @(posedge clock);
    send(8'h55);
    @(negedge clock);
    expect_eq("busy_during_restart", 32'(busy), 32'd1);
    device_frame(1'b1, 0);
    wait_idle("ignore");

    // NACK
`ifdef PS2_TX_RETRY_EN
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    exp_res_q.push_back(2'b01);
    send(8'hED);
    device_frame(1'b0, 0);
    expect_eq("busy_across_retry", 32'(busy), 32'd1);
    device_frame(1'b0, 0);
`else
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    exp_res_q.push_back(2'b01);
    send(8'hED);
    device_frame(1'b0, 0);
`endif
    wait_idle("nack");

    // timeout: device silent after request
    exp_res_q.push_back(2'b01);
    send(8'hA5);
    wait_req(n);
    n = 0;
    while (!error && n < 3000) begin
      @(negedge clock);
      n++;
    end
    expect_eq("timeout_cycles", n, TO);
    expect_eq("timeout_clk_rel",  32'(ps2_clk_drive_low),  32'd0);
    expect_eq("timeout_data_rel", 32'(ps2_data_drive_low), 32'd0);
    expect_eq("timeout_busy",     32'(busy), 32'd0);

    // reset after edge 5
    send(8'hED);
    device_frame(1'b1, 5);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    expect_eq("midrst_clk_rel",  32'(ps2_clk_drive_low),  32'd0);
    expect_eq("midrst_data_rel", 32'(ps2_data_drive_low), 32'd0);
    expect_eq("midrst_busy",     32'(busy), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    dev_clk = 1'b1;
    @(negedge clock);
    expect_eq("postrst_clk_rel",  32'(ps2_clk_drive_low),  32'd0);
    expect_eq("postrst_data_rel", 32'(ps2_data_drive_low), 32'd0);
    expect_eq("postrst_busy",     32'(busy), 32'd0);

    exp_frame_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
    exp_res_q.push_back(2'b10);
    send(8'hF4);
    device_frame(1'b1, 0);
    wait_idle("after_rst");

    repeat (20) @(negedge clock);
    expect_eq("frames_left",  exp_frame_q.size(), 32'd0);
    expect_eq("results_left", exp_res_q.size(), 32'd0);
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the outbound counterpart to the PS/2 receive path and its debounced line inputs.
- Sends one command byte, such as 0xED (set LEDs) or 0xF4 (enable), to a keyboard or mouse.
- Runs the full request-to-send sequence, shifts out data and odd parity on device-generated clock edges, and checks the device acknowledge.
- Drives the open-drain PS/2 lines through active-high drive-low enables; the top level instantiates the tristate pads.

Parameters:
- INHIBIT_CYCLES, 5000: clock cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles from release of clock inhibit to acknowledge before abort (15 ms at 50 MHz).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- send_start  in  1  one-cycle request to transmit send_data.
- send_data  in  8  byte to transmit; sampled on the accepted send_start.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_drive_low  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_drive_low  out  1  1 = pull PS/2 data low; 0 = release.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on successful acknowledged transfer.
- error  out  1  one-cycle pulse on timeout or missing acknowledge.

Behaviour:
- Reset: all outputs 0; both lines released; state IDLE; synchronizer flops set to 1. Reset mid-transfer releases both lines in the same cycle and emits no done/error.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer. A falling edge is "previous synced = 1, current synced = 0".
- send_start is accepted only in IDLE. In any other state it is ignored and send_data is not resampled.
- Transmission uses a 9-bit shift register: send_data plus odd parity (~^send_data), loaded on acceptance.
- IDLE: on send_start, load shift register, set busy=1 next cycle, go to INHIBIT.
- INHIBIT: clk_drive_low=1 for exactly INHIBIT_CYCLES cycles. On the last cycle, assert data_drive_low=1 (start bit).
- REQ: clk_drive_low=0, data_drive_low=1. The timeout counter starts from 0.
- Falling edges 1-9 (REQ, then DATA): on each edge, drive the next shift-register bit, LSB first, parity on edge 9. Drive-low = ~bit.
- Falling edge 10: release data (stop bit = 1), go to ACK.
- ACK: on falling edge 11, sample synced data.
  - 0 → WAIT_IDLE.
  - 1 → NACK: error path.
- WAIT_IDLE: when synced clock and data are both 1 → done=1 for one cycle, busy=0, IDLE.
- Timeout: the counter runs in REQ, DATA, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1: release both lines, error=1 for one cycle, busy=0, IDLE.
- Error path: release both lines, error pulse, busy=0, return to IDLE.
- done and error are never asserted together. busy falls in the same cycle as the done or error pulse.
- Edge count is a 4-bit counter and does not wrap; it is cleared on entry to INHIBIT.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined: on a NACK (ack bit sampled 1), the block automatically restarts from INHIBIT once with the same byte, with busy held high throughout. error is raised only if the retry also NACKs or times out. A timeout never retries.
- Undefined: a NACK raises error immediately. The retry flag and its logic are absent.

Test Plan:
- Bench parameters for all scenarios: INHIBIT_CYCLES=4, TIMEOUT_CYCLES=2000.
- Happy path: send 0xED; device model clocks at 40-cycle period and acks → data bits 1,0,1,1,0,1,1,1, parity 1, stop released; done pulses once; busy low after.
- Parity: send 0xF4 → parity bit 0. Send 0x00 → parity bit 1.
- NACK: device holds data high at edge 11 → error pulses once, both drive_low=0.
  - With PS2_TX_RETRY_EN: a second full frame of the same byte is sent first; error pulses only if the retry also NACKs.
- Timeout: device never clocks after request → error exactly 2000 cycles after REQ entry; lines released.
- Reset mid-frame after edge 5: both drive_low=0 and busy=0 the next cycle; no done/error pulse. A subsequent send of 0xF4 completes normally.
- send_start pulsed while busy with 0x55 → ignored; the frame in flight still carries the original byte; done pulses once.
